// File: rtl/shift_operand_sequencer.sv
// Decode-stage controller in front of the Shifter. It classifies the
// instruction in ID and builds a registered operand-control packet for EX.
// For shift-by-register forms it reads Rs over the shared port-B read path,
// stalling IF/ID until the amount arrives. Packets go to ID/EX via valid/ready.
module shift_operand_sequencer #(
  parameter int unsigned RS_LAT = 1,
  parameter int unsigned N      = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          id_valid_in,
  input  logic [31:0]   instr_in,
  input  logic [N-1:0]  rs_data_in,
  input  logic          ex_ready_in,
  output logic          stall_out,
  output logic          rs_rd_en_out,
  output logic [3:0]    rs_addr_out,
  output logic          op_valid_out,
  output logic [2:0]    type_out,
  output logic [11:0]   shift_out,
  output logic          carry_sel_out,
  output logic          amt_ovf_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RS_WAIT = 2'd1,
    ISSUE   = 2'd2
  } state_t;

  localparam logic [2:0] LAT = 3'(RS_LAT);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  lo_q, lo_d;
  logic [2:0]  type_q, type_d;
  logic [11:0] shift_q, shift_d;
  logic        carry_q, carry_d;
  logic        ovf_q, ovf_d;
  logic        stall_c, rd_en_c;

  logic        is_reg_shift;
  logic        accept;
  logic [2:0]  dec_type;
  logic [11:0] dec_shift;
  logic        dec_carry;
  logic [7:0]  amt;
  logic [11:0] rsh_shift;
  logic        rsh_carry;
  logic        rsh_ovf;

  // Bits of the instruction word and Rs that play no part in this block.
  logic unused_bits;
  assign unused_bits = &{1'b0, instr_in[31:28], instr_in[24:12], rs_data_in[N-1:8]};

  assign is_reg_shift = (instr_in[27:25] == 3'b000) && instr_in[4] && !instr_in[7];
  assign accept       = id_valid_in &&
                        ((state_q == IDLE) || ((state_q == ISSUE) && ex_ready_in));

  // Classify the instruction in ID into Shifter type/shift controls and carry source.
  always_comb begin
    dec_type  = 3'b011;
    dec_shift = instr_in[11:0];
    dec_carry = 1'b1;
    case (instr_in[27:25])
      3'b001: begin
        dec_type  = 3'b001;
        dec_carry = (instr_in[11:8] == 4'd0);
      end
      3'b000: begin
        // bit4 set here means multiply/extra forms; shift-by-register takes the RS_WAIT path
        if (!instr_in[4]) begin
          dec_type  = 3'b000;
          dec_carry = (instr_in[11:5] == 7'd0);
        end
      end
      3'b010: begin
        dec_type  = 3'b010;
        dec_carry = 1'b0;
      end
      3'b011: begin
        dec_type  = 3'b011;
        dec_carry = 1'b0;
      end
      default: begin
        dec_type  = 3'b011;
        dec_carry = 1'b1;
      end
    endcase
  end

  // Build the shift-by-register packet from the latched instruction bits and Rs[7:0].
  always_comb begin
    amt       = rs_data_in[7:0];
    rsh_ovf   = (amt >= 8'd32);
    rsh_carry = (amt == 8'd0);
    // A zero amount degenerates to LSL #0 so the Shifter passes Rm and C through.
    rsh_shift = {amt[4:0], (amt == 8'd0) ? 2'b00 : lo_q[6:5], 1'b0, lo_q[3:0]};
  end

  // Next-state, packet load and the combinational stall/read-request decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    type_d  = type_q;
    shift_d = shift_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    stall_c = 1'b0;
    rd_en_c = 1'b0;
    case (state_q)
      IDLE, ISSUE: begin
        if ((state_q == ISSUE) && !ex_ready_in) begin
          stall_c = 1'b1;
        end else if (accept) begin
          if (is_reg_shift) begin
            stall_c = 1'b1;
            rd_en_c = 1'b1;
            lo_d    = instr_in[6:0];
            cnt_d   = LAT;
            state_d = RS_WAIT;
          end else begin
            type_d  = dec_type;
            shift_d = dec_shift;
            carry_d = dec_carry;
            ovf_d   = 1'b0;
            state_d = ISSUE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RS_WAIT: begin
        stall_c = 1'b1;
        if (cnt_q <= 3'd1) begin
          type_d  = 3'b000;
          shift_d = rsh_shift;
          carry_d = rsh_carry;
          ovf_d   = rsh_ovf;
          cnt_d   = 3'd0;
          state_d = ISSUE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, wait counter, latched instruction bits and the output packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lo_q    <= '0;
      type_q  <= '0;
      shift_q <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      type_q  <= type_d;
      shift_q <= shift_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  // Combinational outputs are gated by reset so everything reads 0 while reset_n is low,
  // even if ID still presents a valid shift-by-register instruction.
  assign stall_out     = reset_n & stall_c;
  assign rs_rd_en_out  = reset_n & rd_en_c;
  assign rs_addr_out   = reset_n ? instr_in[11:8] : '0;
  assign op_valid_out  = (state_q == ISSUE);
  assign type_out      = type_q;
  assign shift_out     = shift_q;
  assign carry_sel_out = carry_q;
  assign amt_ovf_out   = ovf_q;

endmodule
